// File: rtl/input_stream_feeder.sv
// input_stream_feeder: buffers host words in a FIFO and, once a whole frame is
// present, emits it as a gap-free index/value/enable burst for the first layer.
module input_stream_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int INPUT_AMOUNT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] output_index,
  output logic [DATA_WIDTH-1:0] output_value,
  output logic                  output_enable,
  output logic [DATA_WIDTH-1:0] frames_sent
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      FRAME_CNT = CNT_W'(INPUT_AMOUNT);
  localparam logic [DATA_WIDTH-1:0] LAST_IDX  = DATA_WIDTH'(INPUT_AMOUNT - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_nxt;

  logic [DATA_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0] r_value;
  logic                  r_enable;
  logic [DATA_WIDTH-1:0] r_frames;

  logic [DATA_WIDTH-1:0] w_index_nxt;
  logic [DATA_WIDTH-1:0] w_value_nxt;
  logic                  w_enable_nxt;
  logic [DATA_WIDTH-1:0] w_frames_nxt;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_start;
  logic                  w_mid;
  logic                  w_frame_done;
  logic [DATA_WIDTH-1:0] w_head;

  // Ready comes from the registered count only, so a pop never frees a slot early.
  assign in_ready = (r_count < FULL_CNT);
  assign w_push   = in_valid & in_ready;
  assign w_head   = r_mem[r_rd_ptr];

  assign output_index  = r_index;
  assign output_value  = r_value;
  assign output_enable = r_enable;
  assign frames_sent   = r_frames;

  always_comb begin
    w_last       = (r_index == LAST_IDX);
    w_start      = ((r_state == S_IDLE) || w_last) && (r_count >= FRAME_CNT);
    w_mid        = (r_state == S_STREAM) && (r_index < LAST_IDX);
    w_frame_done = (r_state == S_STREAM) && w_last;
    w_pop        = w_start | w_mid;

    w_state_nxt  = S_IDLE;
    w_index_nxt  = '0;
    w_value_nxt  = r_value;
    w_enable_nxt = 1'b0;

    if (w_start) begin
      w_state_nxt  = S_STREAM;
      w_index_nxt  = '0;
      w_value_nxt  = w_head;
      w_enable_nxt = 1'b1;
    end else if (w_mid) begin
      // The whole frame was counted before index 0, so the head is always valid here.
      w_state_nxt  = S_STREAM;
      w_index_nxt  = r_index + DATA_WIDTH'(1);
      w_value_nxt  = w_head;
      w_enable_nxt = 1'b1;
    end

    w_frames_nxt = w_frame_done ? (r_frames + DATA_WIDTH'(1)) : r_frames;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_index  <= '0;
      r_value  <= '0;
      r_enable <= 1'b0;
      r_frames <= '0;
    end else if (clear) begin
      // Flush drops any same-cycle push and does not count an aborted frame.
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_index  <= '0;
      r_enable <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_index  <= w_index_nxt;
      r_value  <= w_value_nxt;
      r_enable <= w_enable_nxt;
      r_frames <= w_frames_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_input_stream_feeder.sv
// Directed bench for input_stream_feeder: default build, a FIFO_DEPTH=4 build for
// back-pressure, and a DATA_WIDTH=8 build for the frames_sent wrap.
module tb_input_stream_feeder;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;

  logic          a_ready, a_en;
  logic [DW-1:0] a_idx, a_val, a_fs;
  logic          b_ready, b_en;
  logic [DW-1:0] b_idx, b_val, b_fs;
  logic          c_ready, c_en;
  logic [7:0]    c_idx, c_val, c_fs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  input_stream_feeder #(.DATA_WIDTH(32), .INPUT_AMOUNT(4), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_ready), .clear(clear), .output_index(a_idx),
    .output_value(a_val), .output_enable(a_en), .frames_sent(a_fs)
  );

  input_stream_feeder #(.DATA_WIDTH(32), .INPUT_AMOUNT(4), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(b_ready), .clear(clear), .output_index(b_idx),
    .output_value(b_val), .output_enable(b_en), .frames_sent(b_fs)
  );

  input_stream_feeder #(.DATA_WIDTH(8), .INPUT_AMOUNT(4), .FIFO_DEPTH(8)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid),
    .in_ready(c_ready), .clear(clear), .output_index(c_idx),
    .output_value(c_val), .output_enable(c_en), .frames_sent(c_fs)
  );

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          en;
    logic [DW-1:0] idx;
    logic [DW-1:0] val;
    logic [DW-1:0] fs;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic v, input int d, input logic en,
                         input int idx, input int val, input int fs);
    vec_t t;
    t.v   = v;
    t.d   = DW'(d);
    t.en  = en;
    t.idx = DW'(idx);
    t.val = DW'(val);
    t.fs  = DW'(fs);
    vecs.push_back(t);
  endtask

  task automatic chk_a(input string name, input logic en, input int idx, input int val, input int fs);
    chk({name, " en"},  DW'(a_en), DW'(en));
    chk({name, " idx"}, a_idx, DW'(idx));
    chk({name, " val"}, a_val, DW'(val));
    chk({name, " fs"},  a_fs, DW'(fs));
  endtask

  task automatic push_a_frame(input int base);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(base + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            emitted;
    int            nxt;
    int            exp_q[$];
    logic [7:0]    cval;
    logic [7:0]    prev_fs;
    logic [7:0]    step_fs;
    logic          seen255;
    logic          wrapped;

    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Table: two back-to-back frames, then a frame whose last word arrives late.
    for (int i = 0; i < 4; i++) add_vec(1, 1, 0, 0, 0, 0);
    add_vec(1, 2, 1, 0, 1, 0);
    add_vec(1, 2, 1, 1, 1, 0);
    add_vec(1, 2, 1, 2, 1, 0);
    add_vec(1, 2, 1, 3, 1, 0);
    add_vec(0, 0, 1, 0, 2, 1);
    add_vec(0, 0, 1, 1, 2, 1);
    add_vec(0, 0, 1, 2, 2, 1);
    add_vec(0, 0, 1, 3, 2, 1);
    add_vec(0, 0, 0, 0, 2, 2);
    add_vec(0, 0, 0, 0, 2, 2);
    add_vec(1, 5, 0, 0, 2, 2);
    add_vec(1, 6, 0, 0, 2, 2);
    add_vec(1, 7, 0, 0, 2, 2);
    for (int i = 0; i < 5; i++) add_vec(0, 0, 0, 0, 2, 2);
    add_vec(1, 8, 0, 0, 2, 2);
    add_vec(0, 0, 1, 0, 5, 2);
    add_vec(0, 0, 1, 1, 6, 2);
    add_vec(0, 0, 1, 2, 7, 2);
    add_vec(0, 0, 1, 3, 8, 2);
    add_vec(0, 0, 0, 0, 8, 3);

    #1;
    chk_a("reset", 1'b0, 0, 0, 0);
    chk("reset a ready", DW'(a_ready), 32'd1);
    chk("reset b ready", DW'(b_ready), 32'd1);
    chk("reset c fs", DW'(c_fs), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      #1;
      chk($sformatf("vec%0d ready", i), DW'(a_ready), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d en", i),  DW'(a_en), DW'(vecs[i].en));
      chk($sformatf("vec%0d idx", i), a_idx, vecs[i].idx);
      chk($sformatf("vec%0d val", i), a_val, vecs[i].val);
      chk($sformatf("vec%0d fs", i),  a_fs, vecs[i].fs);
    end

    // Clear while index 1 is on the outputs, with a push in the same cycle.
    push_a_frame(9);
    @(posedge clk); #1;
    chk_a("clr pre0", 1'b1, 0, 9, 3);
    @(posedge clk); #1;
    chk_a("clr pre1", 1'b1, 1, 10, 3);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd99;
    @(posedge clk); #1;
    chk("clr en", DW'(a_en), 32'd0);
    chk("clr idx", a_idx, 32'd0);
    chk("clr fs", a_fs, 32'd3);
    chk("clr count", DW'(u_a.r_count), 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    push_a_frame(20);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk_a($sformatf("post-clr e%0d", j), 1'b1, j, 20 + j, 3);
    end
    @(posedge clk); #1;
    chk_a("post-clr end", 1'b0, 0, 23, 4);

    // Asynchronous reset between edges in the middle of a frame.
    push_a_frame(30);
    @(posedge clk); #1;
    chk_a("arst pre0", 1'b1, 0, 30, 4);
    @(posedge clk); #1;
    chk_a("arst pre1", 1'b1, 1, 31, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("arst now", 1'b0, 0, 0, 0);
    chk("arst ready", DW'(a_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    push_a_frame(40);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      chk_a($sformatf("post-rst e%0d", j), 1'b1, j, 40 + j, 0);
    end
    @(posedge clk); #1;
    chk_a("post-rst end", 1'b0, 0, 43, 1);

    // Depth-4 build with in_valid held high: ready drops one cycle per frame.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    nxt     = 100;
    emitted = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(nxt);
      #1;
      chk($sformatf("b ready c%0d", cyc), DW'(b_ready),
          DW'((cyc >= 4 && (cyc - 4) % 5 == 0) ? 0 : 1));
      if (b_ready) begin
        exp_q.push_back(nxt);
        nxt++;
      end
      @(posedge clk); #1;
      if (b_en) begin
        chk($sformatf("b idx c%0d", cyc), b_idx, DW'(emitted % 4));
        if (exp_q.size() == 0) begin
          chk("b underflow", 32'd1, 32'd0);
        end else begin
          chk($sformatf("b val c%0d", cyc), b_val, DW'(exp_q.pop_front()));
        end
        emitted++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("b emitted", DW'(emitted), 32'd29);
    chk("b fs", b_fs, 32'd7);

    // 8-bit build streamed continuously until frames_sent wraps 255 -> 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    cval    = 8'd0;
    prev_fs = 8'd0;
    seen255 = 1'b0;
    wrapped = 1'b0;
    for (int cyc = 0; cyc < 1100 && !wrapped; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DW'(cyc);
      #1;
      chk("c ready", DW'(c_ready), 32'd1);
      @(posedge clk); #1;
      if (c_en) begin
        chk("c val", DW'(c_val), DW'(cval));
        chk("c idx", DW'(c_idx), DW'(cval[1:0]));
        cval = cval + 8'd1;
      end
      if (c_fs != prev_fs) begin
        if (seen255) begin
          chk("c wrap", DW'(c_fs), 32'd0);
          wrapped = 1'b1;
        end else begin
          step_fs = prev_fs + 8'd1;
          chk("c fs step", DW'(c_fs), DW'(step_fs));
        end
        if (c_fs == 8'd255) seen255 = 1'b1;
        prev_fs = c_fs;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("c wrap reached", DW'(wrapped), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_stream_feeder.md
# input_stream_feeder

Upstream feeder for the first weight_comp_cell layer. It accepts input-vector elements from a host one word at a time over a valid/ready handshake and buffers them in a FIFO. Once a complete frame of INPUT_AMOUNT elements is buffered, it emits the frame on the layer's index/value/enable stream for exactly INPUT_AMOUNT consecutive cycles, with no gaps inside a frame.

## Interface
- DATA_WIDTH, 32, width of each value and of the index.
- INPUT_AMOUNT, 4, elements per frame (layer input size); must be ≥ 2.
- FIFO_DEPTH, 8, buffer capacity in words; must be a power of two and ≥ INPUT_AMOUNT.
- clk  input  1  the block's one clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  DATA_WIDTH  element from host.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- clear  input  1  synchronous flush; empties the FIFO and aborts any frame in progress.
- output_index  output  DATA_WIDTH  element index within the frame, 0..INPUT_AMOUNT-1.
- output_value  output  DATA_WIDTH  element value.
- output_enable  output  1  output_index and output_value are valid.
- frames_sent  output  DATA_WIDTH  count of frames fully emitted; wraps modulo 2^DATA_WIDTH.

## Operation
- FIFO with read and write pointers of log2(FIFO_DEPTH) bits. Pointers wrap naturally. A separate count register tracks occupancy, 0..FIFO_DEPTH.
- in_ready = (count < FIFO_DEPTH). It is driven from the registered count only; a same-cycle pop does not free a slot early.
- Push: in_valid & in_ready at a rising edge writes in_data and advances the write pointer.
- Two-state FSM: IDLE and STREAM. The output registers are loaded at each edge as follows:
  - Start or continue a frame when (state = IDLE, or output_index = INPUT_AMOUNT-1) and count ≥ INPUT_AMOUNT. Then load index 0 and the FIFO head, set enable = 1, pop, and go to STREAM.
  - Mid-frame: when in STREAM and output_index < INPUT_AMOUNT-1, load index+1 and the FIFO head, keep enable = 1, and pop. Data is guaranteed present because the whole frame was already counted.
  - Otherwise: set enable = 0, set index = 0, hold output_value, and go to IDLE.
- A frame is never split. Once index 0 is emitted, indices 1..INPUT_AMOUNT-1 follow on the next consecutive cycles.
- frames_sent increments at the edge where output_index advances past INPUT_AMOUNT-1, i.e. when the last element has been presented for one cycle.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- clear (highest priority after reset) takes effect at the next edge:
  - Pointers and count go to 0, output_enable goes to 0, output_index goes to 0, state goes to IDLE.
  - A push in the same cycle is discarded.
  - frames_sent is not cleared.
  - A frame aborted by clear is not counted.
- rst_n low, including mid-frame, immediately gives:
  - output_enable = 0, output_index = 0, output_value = 0, frames_sent = 0.
  - count = 0 and pointers = 0, so in_ready = 1.
  - state = IDLE.
  - FIFO storage contents are don't-care.

## Timing
- Latency: if the word that brings count to INPUT_AMOUNT is accepted at edge k, output_enable is high with index 0 after edge k+1.
- Back-to-back frames: if count ≥ INPUT_AMOUNT at the edge after index INPUT_AMOUNT-1 is loaded, index 0 of the next frame follows with no idle cycle.
- Sustained throughput is 1 word per cycle in and 1 element per cycle out.
- The outputs are pure registers with no combinational path from in_valid. in_ready depends only on registers.

## Test plan
- Reset, then push 1,1,1,1,2,2,2,2 on consecutive cycles (defaults) -> enable high for 8 consecutive cycles. Indices are 0,1,2,3,0,1,2,3 with values 1,1,1,1,2,2,2,2. First enable appears one cycle after the 4th word is accepted. frames_sent ends at 2.
- Push 3 words 5,6,7, idle 5 cycles, then push 8 -> enable stays low until 8 is accepted, then index 0..3 carries 5,6,7,8. frames_sent increments by 1.
- FIFO_DEPTH=4, INPUT_AMOUNT=4, in_valid held high -> in_ready is low for the one cycle where count = 4. No word is lost or duplicated, and the output sequence equals the input sequence.
- clear asserted while index 1 of a frame is on the outputs -> enable is low after the next edge and count = 0. frames_sent is unchanged. The next 4 pushes produce a clean frame starting at index 0.
- rst_n pulled low asynchronously mid-frame (between clock edges) -> all outputs reach their reset values immediately, without waiting for a clock edge. After release, a fresh 4-word frame streams correctly.
- Preload frames_sent to near wrap by streaming 2^DATA_WIDTH-1 frames, or check wrap in a reduced DATA_WIDTH=8 build -> frames_sent rolls 255 -> 0.
